nvdla_cacc_psum_assembly: RTL and testbench
===========================================

NVDLA_CACC_PSUM_ASSEMBLY -- requirements
Module: nvdla_cacc_psum_assembly

Interface
REQ-001 SHALL have parameter ATOMK_HALF, default 8: lanes per MAC half.
REQ-002 SHALL have parameter RESULT_WIDTH, default 19: signed partial-sum width per lane.
REQ-003 SHALL have parameter ACC_WIDTH, default 24: signed accumulator width per lane.
REQ-004 SHALL have parameter DEPTH, default 32: stripe positions held, power of two; POS_W = log2(DEPTH).
REQ-005 SHALL have port nvdla_core_clk, in, 1: sole clock.
REQ-006 SHALL have port nvdla_core_rstn, in, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port mac2accu_pvld, in, 1: beat valid; no backpressure.
REQ-008 SHALL have port mac2accu_mask, in, ATOMK_HALF: per-lane valid.
REQ-009 SHALL have port mac2accu_mode, in, 1: 1 = overwrite, no accumulate.
REQ-010 SHALL have port mac2accu_data, in, ATOMK_HALF*RESULT_WIDTH: lane k at [k*RESULT_WIDTH +: RESULT_WIDTH].
REQ-011 SHALL have port mac2accu_pd, in, 9: [0] stripe_st, [1] stripe_end, [2] channel_end, [3] layer_end, [8:4] ignored.
REQ-012 SHALL have port acc_err_clr, in, 1: pulse clearing sticky flags.
REQ-013 SHALL have port acc2dlv_pvld, out, 1: result valid.
REQ-014 SHALL have port acc2dlv_data, out, ATOMK_HALF*ACC_WIDTH: accumulated lanes, same packing.
REQ-015 SHALL have port acc2dlv_pd, out, POS_W+2: {layer_end, stripe_end, pos}.
REQ-016 SHALL have ports acc_overflow and acc_pos_err, out, 1 each: sticky error flags.

Function
REQ-017 SHALL register each valid beat (stage 1), then read, add, write psum buffer and register outputs (stage 2); latency exactly 2 cycles from mac2accu_pvld to acc2dlv_pvld.
REQ-018 SHALL hold pos counter: 0 on a stripe_st beat, else previous+1; pos of beat is that value; counter returns to 0 after a stripe_end beat.
REQ-019 SHALL hold first_pass flag: 1 after reset; on a stripe_end beat, load that beat's channel_end.
REQ-020 SHALL, per lane, compute masked = mask[k] ? sign-extend(data_k) : 0; new = (first_pass | mode) ? masked : buf[pos][k] + masked; write new to buf[pos][k].
REQ-021 SHALL assert acc2dlv_pvld for exactly one cycle only for beats with channel_end=1, carrying new values, pos, stripe_end, layer_end; non-channel_end beats produce no output.
REQ-022 SHALL hold acc2dlv_data/pd stable when acc2dlv_pvld=0.
REQ-023 SHALL, on a beat whose pos would reach DEPTH, wrap pos to 0 and set acc_pos_err.
REQ-024 SHALL set acc_overflow when any lane's signed sum exceeds ACC_WIDTH range.
REQ-025 SHALL give set priority over acc_err_clr when both occur in the same cycle.
REQ-026 SHALL accept back-to-back beats every cycle; same-pos reads in consecutive beats see the prior write (buffer in flops, write completes before next stage-2 read).

Reset
REQ-027 SHALL on rstn low: acc2dlv_pvld=0, acc2dlv_data=0, acc2dlv_pd=0, pos=0, first_pass=1, stage-1 valid=0, acc_overflow=0, acc_pos_err=0.
REQ-028 SHALL not reset the psum buffer; first_pass=1 guarantees overwrite before use.
REQ-029 SHALL discard any in-flight beat when reset asserts mid-stripe; first output after release follows a fresh stripe_st.

Configuration
REQ-030 SHALL, with NVDLA_CACC_SATURATE_EN defined, clamp overflowing lanes to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
REQ-031 SHALL, without NVDLA_CACC_SATURATE_EN, wrap modulo 2^ACC_WIDTH; acc_overflow is set in both builds.

Structure
REQ-032 SHALL place pd bit indices, default widths and DEPTH in shared package nvdla_cacc_pkg.
REQ-033 SHALL implement per-lane add/saturate as sub-module nvdla_cacc_lane_add, instantiated ATOMK_HALF times.

Verification
REQ-034 SHALL cover single pass: 4 beats, first stripe_st, last stripe_end, all channel_end, lane0=5 -> 4 outputs at t+2, lane0=5, pos 0..3.
REQ-035 SHALL cover two groups: pass1 lane3=-7 (channel_end=0), pass2 lane3=10 (channel_end=1) -> no pass1 output; pass2 lane3=3.
REQ-036 SHALL cover masking: mask=8'h0F, lane7=100 -> lane7 output 0.
REQ-037 SHALL cover overflow: 33 passes of lane0=262143 -> 8388607 with macro, wrapped value without; acc_overflow=1 in both.
REQ-038 SHALL cover pos error: 33 beats without stripe_end -> acc_pos_err=1, 33rd beat pos=0; acc_err_clr pulse clears it.
REQ-039 SHALL cover reset mid-stripe: rstn low after beat 2 -> pvld=0; next pass treated as first_pass.

Source files
------------

// File: rtl/nvdla_cacc_pkg.sv
// Shared constants and pd decode for the CACC partial-sum assembly slice.
package nvdla_cacc_pkg;

  localparam int unsigned ATOMK_HALF_DEF   = 8;
  localparam int unsigned RESULT_WIDTH_DEF = 19;
  localparam int unsigned ACC_WIDTH_DEF    = 24;
  localparam int unsigned DEPTH_DEF        = 32;

  localparam int unsigned PD_W           = 9;
  localparam int unsigned PD_STRIPE_ST   = 0;
  localparam int unsigned PD_STRIPE_END  = 1;
  localparam int unsigned PD_CHANNEL_END = 2;
  localparam int unsigned PD_LAYER_END   = 3;

  typedef struct packed {
    logic layer_end;
    logic channel_end;
    logic stripe_end;
    logic stripe_st;
  } beat_flags_t;

  function automatic beat_flags_t decode_flags(input logic [3:0] pd_lo);
    beat_flags_t f;
    f.stripe_st   = pd_lo[PD_STRIPE_ST];
    f.stripe_end  = pd_lo[PD_STRIPE_END];
    f.channel_end = pd_lo[PD_CHANNEL_END];
    f.layer_end   = pd_lo[PD_LAYER_END];
    return f;
  endfunction

endpackage

// File: rtl/nvdla_cacc_psum_assembly_if.sv
// MAC-to-accumulator beat bus and accumulator-to-delivery result bus.
interface nvdla_cacc_psum_assembly_if
  import nvdla_cacc_pkg::*;
#(
  parameter int unsigned ATOMK_HALF   = ATOMK_HALF_DEF,
  parameter int unsigned RESULT_WIDTH = RESULT_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int unsigned POS_W        = 5
);

  logic                               mac2accu_pvld;
  logic [ATOMK_HALF-1:0]              mac2accu_mask;
  logic                               mac2accu_mode;
  logic [ATOMK_HALF*RESULT_WIDTH-1:0] mac2accu_data;
  logic [PD_W-1:0]                    mac2accu_pd;

  logic                               acc2dlv_pvld;
  logic [ATOMK_HALF*ACC_WIDTH-1:0]    acc2dlv_data;
  logic [POS_W+1:0]                   acc2dlv_pd;

  modport master (
    output mac2accu_pvld, mac2accu_mask, mac2accu_mode, mac2accu_data, mac2accu_pd,
    input  acc2dlv_pvld, acc2dlv_data, acc2dlv_pd
  );

  modport slave (
    input  mac2accu_pvld, mac2accu_mask, mac2accu_mode, mac2accu_data, mac2accu_pd,
    output acc2dlv_pvld, acc2dlv_data, acc2dlv_pd
  );

endinterface

// File: rtl/nvdla_cacc_lane_add.sv
// One accumulator lane: mask, sign-extend, add or overwrite, detect overflow.
// NVDLA_CACC_SATURATE_EN clamps overflowing sums; otherwise they wrap.
module nvdla_cacc_lane_add #(
  parameter int unsigned RESULT_WIDTH = 19,
  parameter int unsigned ACC_WIDTH    = 24
) (
  input  logic                    valid,
  input  logic                    clear,
  input  logic [RESULT_WIDTH-1:0] data,
  input  logic [ACC_WIDTH-1:0]    prev,
  output logic [ACC_WIDTH-1:0]    sum,
  output logic                    ovf
);

  logic [ACC_WIDTH:0] masked;
  logic [ACC_WIDTH:0] base;
  logic [ACC_WIDTH:0] total;

  always_comb begin
    masked = valid ? {{(ACC_WIDTH+1-RESULT_WIDTH){data[RESULT_WIDTH-1]}}, data} : '0;
    base   = clear ? '0 : {prev[ACC_WIDTH-1], prev};
    total  = base + masked;
    // one guard bit: top two bits disagree exactly when the signed sum left range
    ovf    = total[ACC_WIDTH] ^ total[ACC_WIDTH-1];
    sum    = total[ACC_WIDTH-1:0];
`ifdef NVDLA_CACC_SATURATE_EN
    if (ovf) begin
      sum = total[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif
  end

endmodule

// File: rtl/nvdla_cacc_psum_assembly.sv
// Two-stage partial-sum assembly: register beat, then read/add/write the psum
// buffer and register results. Build option: NVDLA_CACC_SATURATE_EN.
module nvdla_cacc_psum_assembly
  import nvdla_cacc_pkg::*;
#(
  parameter int unsigned ATOMK_HALF   = ATOMK_HALF_DEF,
  parameter int unsigned RESULT_WIDTH = RESULT_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  nvdla_cacc_psum_assembly_if.slave   bus,
  input  logic                        acc_err_clr,
  output logic                        acc_overflow,
  output logic                        acc_pos_err
);

  localparam int unsigned POS_W = $clog2(DEPTH);

  beat_flags_t flags;
  logic        unused_pd_hi;
  logic [POS_W:0]   pos_cnt;
  logic [POS_W:0]   pos_raw;
  logic [POS_W-1:0] beat_pos;
  logic             pos_ovr;
  logic             first_pass;

  logic                               s1_vld;
  logic [ATOMK_HALF-1:0]              s1_mask;
  logic [ATOMK_HALF*RESULT_WIDTH-1:0] s1_data;
  logic [POS_W-1:0]                   s1_pos;
  logic                               s1_clear;
  logic                               s1_chend;
  logic                               s1_send;
  logic                               s1_lend;

  logic [ACC_WIDTH-1:0]            psum_mem [DEPTH][ATOMK_HALF];
  logic [ATOMK_HALF*ACC_WIDTH-1:0] new_data;
  logic [ATOMK_HALF-1:0]           lane_ovf;

  logic                            out_vld;
  logic [ATOMK_HALF*ACC_WIDTH-1:0] out_data;
  logic [POS_W+1:0]                out_pd;

  assign flags        = decode_flags(bus.mac2accu_pd[3:0]);
  assign unused_pd_hi = ^bus.mac2accu_pd[PD_W-1:4];

  // pos_cnt carries one extra bit so a stripe running past DEPTH is visible
  always_comb begin
    pos_raw  = flags.stripe_st ? '0 : pos_cnt;
    pos_ovr  = pos_raw[POS_W];
    beat_pos = pos_ovr ? '0 : pos_raw[POS_W-1:0];
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_vld      <= 1'b0;
      pos_cnt     <= '0;
      first_pass  <= 1'b1;
      acc_pos_err <= 1'b0;
    end else begin
      s1_vld <= bus.mac2accu_pvld;
      if (bus.mac2accu_pvld) begin
        pos_cnt <= flags.stripe_end ? '0 : (POS_W+1)'(beat_pos) + (POS_W+1)'(1);
        if (flags.stripe_end) begin
          first_pass <= flags.channel_end;
        end
      end
      if (bus.mac2accu_pvld && pos_ovr) begin
        acc_pos_err <= 1'b1;
      end else if (acc_err_clr) begin
        acc_pos_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (bus.mac2accu_pvld) begin
      s1_mask  <= bus.mac2accu_mask;
      s1_data  <= bus.mac2accu_data;
      s1_pos   <= beat_pos;
      s1_clear <= first_pass | bus.mac2accu_mode;
      s1_chend <= flags.channel_end;
      s1_send  <= flags.stripe_end;
      s1_lend  <= flags.layer_end;
    end
  end

  for (genvar k = 0; k < ATOMK_HALF; k++) begin : g_lane
    nvdla_cacc_lane_add #(
      .RESULT_WIDTH (RESULT_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH)
    ) u_add (
      .valid (s1_mask[k]),
      .clear (s1_clear),
      .data  (s1_data[k*RESULT_WIDTH +: RESULT_WIDTH]),
      .prev  (psum_mem[s1_pos][k]),
      .sum   (new_data[k*ACC_WIDTH +: ACC_WIDTH]),
      .ovf   (lane_ovf[k])
    );
  end

  // flop-based buffer: a write here is visible to the very next stage-2 read
  always_ff @(posedge nvdla_core_clk) begin
    if (s1_vld) begin
      for (int unsigned k = 0; k < ATOMK_HALF; k++) begin
        psum_mem[s1_pos][k] <= new_data[k*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_vld      <= 1'b0;
      out_data     <= '0;
      out_pd       <= '0;
      acc_overflow <= 1'b0;
    end else begin
      out_vld <= s1_vld & s1_chend;
      if (s1_vld && s1_chend) begin
        out_data <= new_data;
        out_pd   <= {s1_lend, s1_send, s1_pos};
      end
      if (s1_vld && (|lane_ovf)) begin
        acc_overflow <= 1'b1;
      end else if (acc_err_clr) begin
        acc_overflow <= 1'b0;
      end
    end
  end

  assign bus.acc2dlv_pvld = out_vld;
  assign bus.acc2dlv_data = out_data;
  assign bus.acc2dlv_pd   = out_pd;

endmodule

// File: tb/tb_nvdla_cacc_psum_assembly.sv
// Randomized bench for nvdla_cacc_psum_assembly against a behavioural psum model.
`timescale 1ns/1ps
module tb_nvdla_cacc_psum_assembly;

  localparam int AH = 8, RW = 19, AW = 24, DEPTH = 32, PW = 5;
  localparam longint MAXV = (longint'(1) << (AW-1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW-1));

  logic clk = 1'b0, rstn = 1'b1, err_clr = 1'b0;
  logic acc_overflow, acc_pos_err;
  always #5 clk = ~clk;

  nvdla_cacc_psum_assembly_if #(.ATOMK_HALF(AH), .RESULT_WIDTH(RW), .ACC_WIDTH(AW), .POS_W(PW)) bus ();

  nvdla_cacc_psum_assembly #(.ATOMK_HALF(AH), .RESULT_WIDTH(RW), .ACC_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus),
    .acc_err_clr     (err_clr),
    .acc_overflow    (acc_overflow),
    .acc_pos_err     (acc_pos_err)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string nm, input logic [AH*AW-1:0] act, input logic [AH*AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // model state: per-position lane sums, next position, first-pass flag
  longint mbuf [DEPTH][AH];
  int     mpos_next = 0;
  bit     mfirst = 1'b1;

  typedef struct { int due; logic [AH*AW-1:0] data; logic [PW+1:0] pd; } exp_t;
  typedef struct { longint l0; longint l3; longint l7; int pos; } obs_t;
  exp_t expq[$];
  obs_t obsq[$];

  function automatic longint lane_of(input logic [AH*AW-1:0] d, input int k);
    return longint'($signed(d[k*AW +: AW]));
  endfunction

  function automatic logic [AH*RW-1:0] mk(input int k, input longint v);
    logic [AH*RW-1:0] r;
    r = '0;
    r[k*RW +: RW] = RW'(v);
    return r;
  endfunction

  task automatic beat(input logic [AH-1:0] mask, input bit mode, input logic [AH*RW-1:0] d,
                      input bit st, input bit se, input bit ce, input bit le);
    int p;
    longint v, s;
    logic [AH*AW-1:0] od;
    p = st ? 0 : mpos_next;
    if (p == DEPTH) p = 0;
    od = '0;
    for (int k = 0; k < AH; k++) begin
      v = mask[k] ? longint'($signed(d[k*RW +: RW])) : 0;
      s = (mfirst || mode) ? v : mbuf[p][k] + v;
      if (s > MAXV || s < MINV) begin
`ifdef NVDLA_CACC_SATURATE_EN
        s = (s > MAXV) ? MAXV : MINV;
`else
        s = s & ((longint'(1) << AW) - 1);
        if (s > MAXV) s = s - (longint'(1) << AW);
`endif
      end
      mbuf[p][k] = s;
      od[k*AW +: AW] = AW'(s);
    end
    if (ce) expq.push_back('{cyc + 2, od, {le, se, PW'(p)}});
    mpos_next = se ? 0 : p + 1;
    if (se) mfirst = ce;
    bus.mac2accu_pvld = 1'b1;
    bus.mac2accu_mask = mask;
    bus.mac2accu_mode = mode;
    bus.mac2accu_data = d;
    bus.mac2accu_pd   = {5'($urandom), le, ce, se, st};
    @(negedge clk);
    bus.mac2accu_pvld = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.mac2accu_pvld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  logic [AH*AW-1:0] last_data = '0;
  logic [PW+1:0]    last_pd = '0;

  always @(negedge clk) begin : compare
    exp_t e;
    obs_t o;
    if (!rstn) begin
      chk("rst_pvld", longint'(bus.acc2dlv_pvld), 0);
      chkw("rst_data", bus.acc2dlv_data, '0);
      chk("rst_pd", longint'(bus.acc2dlv_pd), 0);
      last_data = '0;
      last_pd = '0;
    end else if (expq.size() != 0 && expq[0].due <= cyc) begin
      e = expq.pop_front();
      chk("out_latency", cyc, e.due);
      chk("out_pvld", longint'(bus.acc2dlv_pvld), 1);
      chkw("out_data", bus.acc2dlv_data, e.data);
      chk("out_pd", longint'(bus.acc2dlv_pd), longint'(e.pd));
      o.l0 = lane_of(bus.acc2dlv_data, 0);
      o.l3 = lane_of(bus.acc2dlv_data, 3);
      o.l7 = lane_of(bus.acc2dlv_data, 7);
      o.pos = int'(bus.acc2dlv_pd[PW-1:0]);
      obsq.push_back(o);
      last_data = e.data;
      last_pd = e.pd;
    end else begin
      chk("idle_pvld", longint'(bus.acc2dlv_pvld), 0);
      chkw("hold_data", bus.acc2dlv_data, last_data);
      chk("hold_pd", longint'(bus.acc2dlv_pd), longint'(last_pd));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int L, P;
    logic [AH*RW-1:0] d;
    logic [AH-1:0] m;
    bit md, le;
    bus.mac2accu_pvld = 1'b0;
    bus.mac2accu_mask = '0;
    bus.mac2accu_mode = 1'b0;
    bus.mac2accu_data = '0;
    bus.mac2accu_pd   = '0;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_overflow", longint'(acc_overflow), 0);
    chk("rst_pos_err", longint'(acc_pos_err), 0);
    #1 rstn = 1'b1;
    @(negedge clk);

    // single pass, four positions
    obsq.delete();
    for (int i = 0; i < 4; i++) beat('1, 1'b0, mk(0, 5), i == 0, i == 3, 1'b1, 1'b0);
    idle(3);
    chk("single_count", obsq.size(), 4);
    for (int i = 0; i < 4 && i < obsq.size(); i++) begin
      chk("single_lane0", obsq[i].l0, 5);
      chk("single_pos", obsq[i].pos, i);
    end

    // two passes in one channel group
    obsq.delete();
    beat('1, 1'b0, mk(3, -7), 1'b1, 1'b1, 1'b0, 1'b0);
    beat('1, 1'b0, mk(3, 10), 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);
    chk("group_count", obsq.size(), 1);
    if (obsq.size() > 0) chk("group_lane3", obsq[0].l3, 3);

    // lane masking
    obsq.delete();
    beat(8'h0F, 1'b0, mk(7, 100) | mk(0, 1), 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    chk("mask_count", obsq.size(), 1);
    if (obsq.size() > 0) begin
      chk("mask_lane7", obsq[0].l7, 0);
      chk("mask_lane0", obsq[0].l0, 1);
    end

    // accumulator overflow over 33 passes
    obsq.delete();
    for (int i = 0; i < 33; i++) beat('1, 1'b0, mk(0, 262143), 1'b1, 1'b1, i == 32, 1'b0);
    idle(3);
    chk("ovf_count", obsq.size(), 1);
`ifdef NVDLA_CACC_SATURATE_EN
    if (obsq.size() > 0) chk("ovf_lane0", obsq[0].l0, 8388607);
`else
    if (obsq.size() > 0) chk("ovf_lane0", obsq[0].l0, -8126497);
`endif
    chk("ovf_flag", longint'(acc_overflow), 1);
    clr_pulse();
    chk("ovf_cleared", longint'(acc_overflow), 0);

    // stripe running past DEPTH
    obsq.delete();
    for (int i = 0; i < 33; i++) beat('1, 1'b0, mk(0, i), i == 0, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("poserr_flag", longint'(acc_pos_err), 1);
    chk("poserr_count", obsq.size(), 33);
    if (obsq.size() == 33) begin
      chk("poserr_pos31", obsq[31].pos, 31);
      chk("poserr_pos_wrap", obsq[32].pos, 0);
      chk("poserr_lane0", obsq[32].l0, 32);
    end
    clr_pulse();
    chk("poserr_cleared", longint'(acc_pos_err), 0);

    // reset in the middle of an accumulating pass
    obsq.delete();
    beat('1, 1'b0, mk(0, 50), 1'b1, 1'b1, 1'b0, 1'b0);
    beat('1, 1'b0, mk(0, 7), 1'b1, 1'b0, 1'b0, 1'b0);
    beat('1, 1'b0, mk(0, 7), 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rstn = 1'b0;
    expq.delete();
    mfirst = 1'b1;
    mpos_next = 0;
    repeat (2) @(negedge clk);
    chk("midrst_pvld", longint'(bus.acc2dlv_pvld), 0);
    #1 rstn = 1'b1;
    @(negedge clk);
    beat('1, 1'b0, mk(0, 4), 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    chk("midrst_count", obsq.size(), 1);
    if (obsq.size() > 0) chk("midrst_lane0", obsq[0].l0, 4);

    // randomized channel groups
    for (int g = 0; g < 60; g++) begin
      L = $urandom_range(1, 8);
      P = $urandom_range(1, 4);
      for (int p = 0; p < P; p++) begin
        for (int b = 0; b < L; b++) begin
          for (int k = 0; k < AH; k++) d[k*RW +: RW] = RW'($urandom);
          m  = ($urandom_range(0, 3) == 0) ? AH'($urandom) : '1;
          md = ($urandom_range(0, 7) == 0);
          le = (p == P-1) && (b == L-1) && ($urandom_range(0, 1) == 1);
          beat(m, md, d, b == 0, b == L-1, p == P-1, le);
          if ($urandom_range(0, 4) == 0) idle(1);
        end
      end
    end
    idle(5);
    chk("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
